// File: rtl/ahb_cmd_pkg.sv
// rtl/ahb_cmd_pkg.sv - shared types and constants for the AHB command sequencer
//
// Purpose: HTRANS encodings, beat counts, FSM state enum and the packed
// command record that travels through the command FIFO.
// Ports: none (package).
package ahb_cmd_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] BEATS_SINGLE = 3'd1;
  localparam logic [2:0] BEATS_INCR4  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Field order fixes the packed layout: {write, addr, size, offset, burst}.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  offset;
    logic        burst;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic [2:0] cmd_beats(input logic burst);
    return burst ? BEATS_INCR4 : BEATS_SINGLE;
  endfunction

endpackage

// File: rtl/ahb_sync_fifo.sv
// rtl/ahb_sync_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: register-array FIFO whose head entry is always visible on dout.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write strobe and data (ignored when full)
//   pop           read strobe (ignored when empty)
//   dout          head entry
//   count         number of stored entries
//   full, empty   status flags
module ahb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ahb_cmd_queue.sv
// rtl/ahb_cmd_queue.sv - host command sequencer feeding the AHB master
//
// Purpose: buffers host commands and write data, launches each command as a
// single or INCR4 transfer once its data/space is reserved, tracks beats on
// htrans/hready/hresp and collects read data into a response FIFO.
// Ports:
//   hclk, hreset                    clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*          command push (write, addr, size, offset, burst)
//   wd_valid/ready, wd_data         write-data push
//   rd_valid/ready, rd_data         read-data pop
//   start, burst, hwrite_in, haddr_in, hwdata_in, hsize_in, offset_in,
//   data_ready                      command interface to the AHB master
//   htrans, hready, hresp, hrdata_out  bus / master taps
//   busy                            sequencer active or commands queued
//   err                             one-cycle pulse on an aborted command
module ahb_cmd_queue
  import ahb_cmd_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int WD_DEPTH  = 8,
  parameter int RD_DEPTH  = 8
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_offset,
  input  logic        cmd_burst,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        start,
  output logic        burst,
  output logic        hwrite_in,
  output logic        data_ready,
  output logic [31:0] haddr_in,
  output logic [31:0] hwdata_in,
  output logic [2:0]  hsize_in,
  output logic [1:0]  offset_in,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata_out,
  output logic        busy,
  output logic        err
);

  localparam int CAW = $clog2(CMD_DEPTH) + 1;
  localparam int WAW = $clog2(WD_DEPTH) + 1;
  localparam int RAW = $clog2(RD_DEPTH) + 1;

  cmd_t           w_cmd_in;
  cmd_t           w_head;
  logic           w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic [CAW-1:0] w_cmd_count;
  logic           w_wd_push, w_wd_pop, w_wd_full, w_wd_empty;
  logic [WAW-1:0] w_wd_count;
  logic [31:0]    w_wd_dout;
  logic           w_rd_push, w_rd_pop, w_rd_full, w_rd_empty;
  logic [RAW-1:0] w_rd_count, w_rd_free;

  state_t         r_state;
  logic           r_start, r_burst, r_hwrite, r_data_ready, r_err;
  logic [31:0]    r_haddr;
  logic [2:0]     r_hsize;
  logic [1:0]     r_offset;
  logic [2:0]     r_addr_cnt, r_data_cnt, r_drain;
  logic           r_pend;

  logic [2:0]     w_beats;
  logic           w_res_ok, w_launch, w_done, w_abort;
  logic           w_addr_beat, w_data_done;

  // ---------------------------------------------------------------- FIFOs
  assign w_cmd_in   = {cmd_write, cmd_addr, cmd_size, cmd_offset, cmd_burst};
  assign cmd_ready  = !w_cmd_full && !hreset;
  assign w_cmd_push = cmd_valid && cmd_ready;
  assign wd_ready   = !w_wd_full && !hreset;
  assign w_wd_push  = wd_valid && wd_ready;
  assign rd_valid   = !w_rd_empty;
  assign w_rd_pop   = rd_valid && rd_ready;

  ahb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(hclk), .rst(hreset), .push(w_cmd_push), .din(w_cmd_in),
    .pop(w_cmd_pop), .dout(w_head), .count(w_cmd_count),
    .full(w_cmd_full), .empty(w_cmd_empty)
  );

  ahb_sync_fifo #(.WIDTH(32), .DEPTH(WD_DEPTH)) u_wd_fifo (
    .clk(hclk), .rst(hreset), .push(w_wd_push), .din(wd_data),
    .pop(w_wd_pop), .dout(w_wd_dout), .count(w_wd_count),
    .full(w_wd_full), .empty(w_wd_empty)
  );

  ahb_sync_fifo #(.WIDTH(32), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk(hclk), .rst(hreset), .push(w_rd_push), .din(hrdata_out),
    .pop(w_rd_pop), .dout(rd_data), .count(w_rd_count),
    .full(w_rd_full), .empty(w_rd_empty)
  );

  // ------------------------------------------------------- control strobes
  // The head command stays in the FIFO until it completes or aborts, so it
  // is the reference for beat count and direction throughout LAUNCH/RUN.
  assign w_beats   = cmd_beats(w_head.burst);
  assign w_rd_free = RAW'(RD_DEPTH) - w_rd_count;
  assign w_res_ok  = w_head.write ? (32'(w_wd_count) >= 32'(w_beats))
                                  : (32'(w_rd_free)  >= 32'(w_beats));
  // Launch waits for any abort drain so stale write data never feeds a new command.
  assign w_launch  = (r_state == ST_IDLE) && !w_cmd_empty && (r_drain == 3'd0) && w_res_ok;

  assign w_done    = (r_state == ST_RUN) && (r_data_cnt == w_beats);
  assign w_abort   = (r_state == ST_RUN) && !w_done && hresp;

  // Address phases beyond the command's beat count are not ours to track.
  assign w_addr_beat = (r_state == ST_RUN) && !w_done && !hresp && hready &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) &&
                       (r_addr_cnt < w_beats);
  assign w_data_done = (r_state == ST_RUN) && !w_done && !hresp && hready && r_pend;

  assign w_cmd_pop = w_done || w_abort;
  assign w_wd_pop  = (w_data_done && r_hwrite) || (r_drain != 3'd0);
  assign w_rd_push = w_data_done && !r_hwrite && !w_rd_full;

  // -------------------------------------------------------------- outputs
  assign start      = r_start;
  assign burst      = r_burst;
  assign hwrite_in  = r_hwrite;
  assign haddr_in   = r_haddr;
  assign hsize_in   = r_hsize;
  assign offset_in  = r_offset;
  assign data_ready = r_data_ready;
  assign err        = r_err;
  assign hwdata_in  = w_wd_empty ? 32'd0 : w_wd_dout;
  assign busy       = (r_state != ST_IDLE) || (w_cmd_count != '0) || w_cmd_empty == 1'b0;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state      <= ST_IDLE;
      r_start      <= 1'b0;
      r_burst      <= 1'b0;
      r_hwrite     <= 1'b0;
      r_haddr      <= '0;
      r_hsize      <= '0;
      r_offset     <= '0;
      r_data_ready <= 1'b0;
      r_err        <= 1'b0;
      r_addr_cnt   <= '0;
      r_data_cnt   <= '0;
      r_drain      <= '0;
      r_pend       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_drain != 3'd0) r_drain <= r_drain - 3'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state  <= ST_LAUNCH;
            r_start  <= 1'b1;
            r_burst  <= w_head.burst;
            r_hwrite <= w_head.write;
            r_haddr  <= w_head.addr;
            r_hsize  <= w_head.size;
            r_offset <= w_head.offset;
          end
        end

        ST_LAUNCH: begin
          r_start      <= 1'b0;
          r_data_ready <= 1'b1;
          r_addr_cnt   <= '0;
          r_data_cnt   <= '0;
          r_pend       <= 1'b0;
          r_state      <= ST_RUN;
        end

        ST_RUN: begin
          if (w_done || w_abort) begin
            r_state      <= ST_IDLE;
            r_data_ready <= 1'b0;
            r_burst      <= 1'b0;
            r_hwrite     <= 1'b0;
            r_haddr      <= '0;
            r_hsize      <= '0;
            r_offset     <= '0;
            r_pend       <= 1'b0;
            if (w_abort) begin
              r_err <= 1'b1;
              // Write data reserved for beats that will never complete.
              if (r_hwrite) r_drain <= w_beats - r_data_cnt;
            end
          end else begin
            if (w_addr_beat) r_addr_cnt <= r_addr_cnt + 3'd1;
            if (w_data_done) r_data_cnt <= r_data_cnt + 3'd1;
            // A ready cycle retires the previous data phase and opens the next one.
            if (hready) r_pend <= w_addr_beat;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_cmd_queue.sv
// tb/tb_ahb_cmd_queue.sv - directed self-checking bench for ahb_cmd_queue
module tb_ahb_cmd_queue;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_burst;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_offset;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        start, burst, hwrite_in, data_ready;
  logic [31:0] haddr_in, hwdata_in;
  logic [2:0]  hsize_in;
  logic [1:0]  offset_in;
  logic [1:0]  htrans;
  logic        hready, hresp;
  logic [31:0] hrdata_out;
  logic        busy, err;

  int checks = 0;
  int passed = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  always #5 hclk = ~hclk;

  ahb_cmd_queue #(.CMD_DEPTH(4), .WD_DEPTH(8), .RD_DEPTH(8)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_offset(cmd_offset),
    .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .start(start), .burst(burst), .hwrite_in(hwrite_in), .data_ready(data_ready),
    .haddr_in(haddr_in), .hwdata_in(hwdata_in), .hsize_in(hsize_in),
    .offset_in(offset_in),
    .htrans(htrans), .hready(hready), .hresp(hresp), .hrdata_out(hrdata_out),
    .busy(busy), .err(err)
  );

  always @(negedge hclk) begin
    if (start === 1'b1) start_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [1:0] o, input logic b);
    cmd_write = w; cmd_addr = a; cmd_size = s; cmd_offset = o; cmd_burst = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic push_wd(input logic [31:0] d);
    wd_data = d; wd_valid = 1'b1;
    step();
    wd_valid = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_offset = 0; cmd_burst = 0;
    wd_valid = 0; wd_data = 0; rd_ready = 0;
    htrans = 2'b00; hready = 1'b1; hresp = 1'b0; hrdata_out = 0;
    step(); step();
    checks++; if ({start, burst, hwrite_in, data_ready, err, busy, rd_valid} !== 7'b0)
      $display("FAIL rst_flags: got %b expected 0000000", {start, burst, hwrite_in, data_ready, err, busy, rd_valid});
    else passed++;
    checks++; if (haddr_in !== 32'd0) $display("FAIL rst_haddr: got %h expected 0", haddr_in); else passed++;
    checks++; if (hwdata_in !== 32'd0) $display("FAIL rst_hwdata: got %h expected 0", hwdata_in); else passed++;
    checks++; if ({hsize_in, offset_in} !== 5'd0) $display("FAIL rst_size_off: got %h expected 0", {hsize_in, offset_in}); else passed++;
    checks++; if ({cmd_ready, wd_ready} !== 2'b00) $display("FAIL rst_ready_in_reset: got %b expected 00", {cmd_ready, wd_ready}); else passed++;
    hreset = 1'b0;
    #1;
    checks++; if ({cmd_ready, wd_ready} !== 2'b11) $display("FAIL rst_ready_after: got %b expected 11", {cmd_ready, wd_ready}); else passed++;
  endtask

  task automatic test_single_read();
    int s0;
    s0 = start_cnt;
    push_cmd(1'b0, 32'h0000_2004, 3'd2, 2'd0, 1'b0);
    checks++; if ({busy, start} !== 2'b10) $display("FAIL sr_queued: got busy/start %b expected 10", {busy, start}); else passed++;
    step();
    checks++; if (start !== 1'b1) $display("FAIL sr_start_latency: got %b expected 1", start); else passed++;
    checks++; if ({haddr_in, hsize_in, hwrite_in, burst} !== {32'h0000_2004, 3'd2, 1'b0, 1'b0})
      $display("FAIL sr_fields: got %h/%0d/%b/%b expected 00002004/2/0/0", haddr_in, hsize_in, hwrite_in, burst);
    else passed++;
    step();
    checks++; if ({start, data_ready} !== 2'b01) $display("FAIL sr_run: got start/data_ready %b expected 01", {start, data_ready}); else passed++;
    htrans = 2'b10; step();
    htrans = 2'b00; hrdata_out = 32'hA5A5_0001; step();
    hrdata_out = 32'd0;
    checks++; if ({rd_valid, rd_data} !== {1'b1, 32'hA5A5_0001})
      $display("FAIL sr_rdata: got %b/%h expected 1/a5a50001", rd_valid, rd_data);
    else passed++;
    step();
    checks++; if ({busy, data_ready} !== 2'b00) $display("FAIL sr_done: got busy/data_ready %b expected 00", {busy, data_ready}); else passed++;
    checks++; if (start_cnt - s0 !== 1) $display("FAIL sr_start_count: got %0d expected 1", start_cnt - s0); else passed++;
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) $display("FAIL sr_rd_pop: got %b expected 0", rd_valid); else passed++;
  endtask

  task automatic test_incr4_write();
    logic [31:0] exp_wd [4];
    exp_wd = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) push_wd(exp_wd[i]);
    push_cmd(1'b1, 32'h0000_4000, 3'd2, 2'd0, 1'b1);
    step();
    checks++; if ({start, burst, hwrite_in, haddr_in} !== {3'b111, 32'h0000_4000})
      $display("FAIL wr_launch: got %b%b%b/%h expected 111/00004000", start, burst, hwrite_in, haddr_in);
    else passed++;
    step();
    htrans = 2'b10; step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (hwdata_in !== exp_wd[k]) $display("FAIL wr_hwdata[%0d]: got %h expected %h", k, hwdata_in, exp_wd[k]); else passed++;
      htrans = (k < 3) ? 2'b11 : 2'b00;
      step();
    end
    checks++; if (data_ready !== 1'b1) $display("FAIL wr_still_run: got %b expected 1", data_ready); else passed++;
    step();
    checks++; if ({busy, data_ready, hwdata_in} !== 34'd0)
      $display("FAIL wr_done_wd_empty: got %b/%b/%h expected 0/0/0", busy, data_ready, hwdata_in);
    else passed++;
  endtask

  task automatic test_gating_wait_states();
    int s0;
    s0 = start_cnt;
    push_wd(32'h51); push_wd(32'h52); push_wd(32'h53);
    push_cmd(1'b1, 32'h0000_5000, 3'd2, 2'd0, 1'b1);
    step(); step(); step();
    checks++; if (start_cnt - s0 !== 0) $display("FAIL gate_no_start: got %0d starts expected 0", start_cnt - s0); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL gate_busy: got %b expected 1", busy); else passed++;
    push_wd(32'h54);
    checks++; if (start !== 1'b0) $display("FAIL gate_start_early: got %b expected 0", start); else passed++;
    step();
    checks++; if (start !== 1'b1) $display("FAIL gate_start_2cyc: got %b expected 1", start); else passed++;
    step();
    htrans = 2'b10; step();
    checks++; if (hwdata_in !== 32'h51) $display("FAIL ws_d0: got %h expected 51", hwdata_in); else passed++;
    htrans = 2'b11; step();
    checks++; if (hwdata_in !== 32'h52) $display("FAIL ws_d1: got %h expected 52", hwdata_in); else passed++;
    hready = 1'b0; step();
    checks++; if (hwdata_in !== 32'h52) $display("FAIL ws_hold1: got %h expected 52", hwdata_in); else passed++;
    step();
    checks++; if (hwdata_in !== 32'h52) $display("FAIL ws_hold2: got %h expected 52", hwdata_in); else passed++;
    hready = 1'b1; step();
    checks++; if (hwdata_in !== 32'h53) $display("FAIL ws_d2: got %h expected 53", hwdata_in); else passed++;
    step();
    checks++; if (hwdata_in !== 32'h54) $display("FAIL ws_d3: got %h expected 54", hwdata_in); else passed++;
    htrans = 2'b00; step();
    checks++; if (data_ready !== 1'b1) $display("FAIL ws_still_run: got %b expected 1", data_ready); else passed++;
    step();
    checks++; if ({busy, data_ready, hwdata_in} !== 34'd0)
      $display("FAIL ws_done: got %b/%b/%h expected 0/0/0", busy, data_ready, hwdata_in);
    else passed++;
  endtask

  task automatic test_error_abort();
    int e0;
    e0 = err_cnt;
    push_wd(32'h61); push_wd(32'h62); push_wd(32'h63); push_wd(32'h64);
    push_cmd(1'b1, 32'h0000_6000, 3'd2, 2'd0, 1'b1);
    push_cmd(1'b0, 32'h0000_7000, 3'd2, 2'd0, 1'b0);
    checks++; if ({start, haddr_in} !== {1'b1, 32'h0000_6000}) $display("FAIL err_launch_a: got %b/%h expected 1/00006000", start, haddr_in); else passed++;
    step();
    htrans = 2'b10; step();
    htrans = 2'b11; step();
    step();
    htrans = 2'b00; hready = 1'b0; hresp = 1'b1; step();
    hresp = 1'b0; hready = 1'b1;
    checks++; if ({err, busy, data_ready} !== 3'b110) $display("FAIL err_pulse: got err/busy/dr %b expected 110", {err, busy, data_ready}); else passed++;
    step();
    checks++; if ({err, start} !== 2'b00) $display("FAIL err_drain1: got err/start %b expected 00", {err, start}); else passed++;
    step();
    checks++; if (start !== 1'b0) $display("FAIL err_drain2: got start %b expected 0", start); else passed++;
    step();
    checks++; if ({start, hwrite_in, haddr_in} !== {2'b10, 32'h0000_7000})
      $display("FAIL err_launch_b: got %b%b/%h expected 10/00007000", start, hwrite_in, haddr_in);
    else passed++;
    checks++; if (hwdata_in !== 32'd0) $display("FAIL err_wd_discarded: got %h expected 0", hwdata_in); else passed++;
    checks++; if (err_cnt - e0 !== 1) $display("FAIL err_count: got %0d expected 1", err_cnt - e0); else passed++;
    step();
    htrans = 2'b10; step();
    htrans = 2'b00; hrdata_out = 32'hBEEF_0002; step();
    hrdata_out = 32'd0;
    checks++; if (rd_data !== 32'hBEEF_0002) $display("FAIL err_b_rdata: got %h expected beef0002", rd_data); else passed++;
    step();
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    checks++; if ({busy, rd_valid} !== 2'b00) $display("FAIL err_b_done: got busy/rd_valid %b expected 00", {busy, rd_valid}); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    push_cmd(1'b0, 32'h0000_8000, 3'd2, 2'd0, 1'b1);
    step(); step();
    htrans = 2'b10; step();
    htrans = 2'b11; hrdata_out = 32'hD0; step();
    hrdata_out = 32'hD1; step();
    checks++; if (rd_valid !== 1'b1) $display("FAIL rm_data_before: got %b expected 1", rd_valid); else passed++;
    hrdata_out = 32'hD2; hreset = 1'b1; step();
    checks++; if ({start, burst, hwrite_in, data_ready, err, busy, rd_valid} !== 7'b0)
      $display("FAIL rm_flags: got %b expected 0000000", {start, burst, hwrite_in, data_ready, err, busy, rd_valid});
    else passed++;
    checks++; if ({haddr_in, hwdata_in, hsize_in, offset_in} !== 69'd0)
      $display("FAIL rm_buses: got %h/%h/%h/%h expected 0", haddr_in, hwdata_in, hsize_in, offset_in);
    else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rm_ready_in_reset: got %b expected 0", cmd_ready); else passed++;
    hreset = 1'b0; htrans = 2'b00; hrdata_out = 32'd0;
    #1;
    checks++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL rm_after_release: got %b expected 10", {cmd_ready, busy}); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_incr4_write();
    test_gating_wait_states();
    test_error_abort();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ahb_cmd_queue.md
# ahb_cmd_queue

Host-side command sequencer that sits directly upstream of the AHB master in the AHB subsystem and drives its command inputs (start, burst, hwrite_in, haddr_in, hwdata_in, hsize_in, offset_in, data_ready). Host commands and write data are buffered in FIFOs. Each command is launched as a single or INCR4 transfer, and beat completion is tracked by tapping htrans, hready and hresp. Read data from the master's hrdata_out is collected into a response FIFO.

## Interface
- CMD_DEPTH, 4, command FIFO entries (power of 2)
- WD_DEPTH, 8, write-data FIFO entries (≥4, power of 2)
- RD_DEPTH, 8, read-data FIFO entries (≥4, power of 2)
- hclk  in  1  clock, rising edge
- hreset  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1  command push handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  start address
- cmd_size  in  3  hsize
- cmd_offset  in  2  byte offset
- cmd_burst  in  1  0 = single beat, 1 = INCR4 (4 beats)
- wd_valid / wd_ready  in/out  1  write-data push handshake; wd_data  in  32
- rd_valid / rd_ready  out/in  1  read-data pop handshake; rd_data  out  32
- start, burst, hwrite_in, data_ready  out  1  to master
- haddr_in, hwdata_in  out  32; hsize_in  out  3; offset_in  out  2  to master
- htrans  in  2; hready  in  1; hresp  in  1; hrdata_out  in  32  bus/master taps
- busy  out  1  FSM not in IDLE, or command FIFO non-empty
- err  out  1  one-cycle pulse on an aborted command

## Operation
- Push rules:
  - Push accepted when valid && ready.
  - cmd_ready = !cmd_full && !hreset; wd_ready = !wd_full && !hreset.
  - rd_valid = !rd_empty.
- beats = cmd_burst ? 4 : 1.
- FSM states: IDLE, LAUNCH, RUN.
- IDLE → LAUNCH when the command FIFO is non-empty and resources are reserved:
  - write: wd count ≥ beats;
  - read: rd free slots ≥ beats.
  - Otherwise stay in IDLE (no partial launch).
- LAUNCH (one cycle):
  - start=1.
  - Head command fields drive burst/hwrite_in/haddr_in/hsize_in/offset_in.
  - Clear addr_cnt and data_cnt (3 bits each). → RUN.
- RUN:
  - Command fields stay driven from the FIFO head; start=0.
  - Address beat: htrans ∈ {NONSEQ=2'b10, SEQ=2'b11} && hready; addr_cnt++, and a pending-data flag is set.
  - Data beat completes on the next hready=1 cycle with the pending flag set:
    - write: pop the wd FIFO; hwdata_in always equals the wd head.
    - read: push hrdata_out into the rd FIFO.
    - data_cnt++.
  - data_ready=1 throughout RUN.
  - data_cnt == beats → pop command, return to IDLE.
- hresp=1 in RUN:
  - Abort: pop the command.
  - For writes, discard the remaining (beats − data_cnt) wd entries (one per cycle, via an internal drain counter that stalls IDLE launch).
  - No push on the errored read beat.
  - Pulse err. → IDLE.
- Simultaneous push and pop on any FIFO: both take effect, count unchanged; a push to a full FIFO is impossible because ready=0.

## Timing
- Reset values:
  - state IDLE; all FIFOs empty.
  - start, burst, hwrite_in, data_ready, err, busy, rd_valid = 0.
  - haddr_in, hwdata_in, hsize_in, offset_in = 0.
- hreset asserted mid-transfer: state and all FIFOs are cleared next edge; in-flight data is lost.
- Latency:
  - Command pushed into an empty queue with resources ready → start high 2 cycles later (1 cycle FIFO write, 1 cycle IDLE→LAUNCH).
  - Read data visible on rd_data 1 cycle after its hready completion.
- Back-to-back: IDLE is occupied at least one cycle between commands; start pulses are ≥3 cycles apart.
- FIFO outputs are first-word-fall-through from registered storage; no combinational path from hrdata_out to rd_data.

## Structure
- Package ahb_cmd_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ constants, BEATS_SINGLE=1, BEATS_INCR4=4, FSM state enum, command record (write, addr, size, offset, burst = 39 bits).
- Sub-module ahb_sync_fifo:
  - Parameters WIDTH, DEPTH; outputs count/full/empty; synchronous active-high reset.
  - Instantiated three times: command (39 bits), write data, read data.

## Test plan
- Single read: cmd (read, 0x0000_2004, size 2, burst 0); one NONSEQ+hready, then hready with hrdata_out=0xA5A5_0001 → start pulses once, rd_data=0xA5A5_0001, rd_valid=1, busy falls.
- INCR4 write: push wd 0x11,0x22,0x33,0x44, then cmd (write, 0x0000_4000, burst 1) → burst=1, hwdata_in takes 0x11..0x44 on successive completions, wd FIFO empty afterwards.
- Resource gating: INCR4 write with only 3 wd entries → start stays 0; push the 4th entry → start 2 cycles later.
- Wait states: hready low 2 cycles mid-burst → hwdata_in holds its value, no extra pop, data_cnt reaches 4 exactly.
- Error abort: INCR4 write, hresp=1 on beat 2 → err pulses once, 2 remaining wd entries discarded, next queued command launches correctly.
- Reset mid-burst: hreset during beat 3 of a read → next cycle all outputs 0, rd_valid=0, cmd_ready=1 after release.
